// File: rtl/mux_arbiter.sv
// Round-robin arbiter that steers an external 3:1 select netlist via c1/c2,
// captures the selected word one cycle later and holds it until the consumer takes it.
module mux_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] mux_y,
    input  logic       out_ready,
    output logic       c1,
    output logic       c2,
    output logic [2:0] ack,
    output logic [2:0] out_data,
    output logic       out_valid,
    output logic [7:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] last_q, last_d;
    logic       c1_q, c1_d;
    logic       c2_q, c2_d;
    logic [2:0] ack_q, ack_d;
    logic [2:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] xfer_cnt_q, xfer_cnt_d;

    logic [1:0] rr_idx0, rr_idx1, rr_idx2;
    logic [1:0] rr_pick;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        next_idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    req_at = r[0];
            2'd1:    req_at = r[1];
            2'd2:    req_at = r[2];
            default: req_at = 1'b0;
        endcase
    endfunction

    // Search order starts just after the last acknowledged requester and wraps.
    always_comb begin
        rr_idx0 = next_idx(last_q);
        rr_idx1 = next_idx(rr_idx0);
        rr_idx2 = next_idx(rr_idx1);
        if (req_at(req, rr_idx0)) begin
            rr_pick = rr_idx0;
        end else if (req_at(req, rr_idx1)) begin
            rr_pick = rr_idx1;
        end else begin
            rr_pick = rr_idx2;
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        ack_d       = 3'b000;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    winner_d = rr_pick;
                    c2_d     = (rr_pick == 2'd0);
                    c1_d     = (rr_pick == 2'd2);
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                // A requester that dropped before capture forfeits its turn without an ack.
                if (req_at(req, winner_q)) begin
                    out_data_d  = mux_y;
                    out_valid_d = 1'b1;
                    ack_d       = 3'b001 << winner_q;
                    last_d      = winner_q;
                    state_d     = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    xfer_cnt_d  = xfer_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            winner_q    <= 2'd0;
            last_q      <= 2'd2;
            c1_q        <= 1'b0;
            c2_q        <= 1'b0;
            ack_q       <= 3'b000;
            out_data_q  <= 3'd0;
            out_valid_q <= 1'b0;
            xfer_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            ack_q       <= ack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign c1        = c1_q;
    assign c2        = c2_q;
    assign ack       = ack_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: models the external 3:1 select netlist and
// checks grants, captured words, handshake timing, aborts, reset and counter wrap.
module tb_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] mux_y;
    logic       out_ready;
    logic       c1;
    logic       c2;
    logic [2:0] ack;
    logic [2:0] out_data;
    logic       out_valid;
    logic [7:0] xfer_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [2:0] W1 = 3'd5;
    localparam logic [2:0] W2 = 3'd3;
    localparam logic [2:0] W3 = 3'd6;

    mux_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_y     (mux_y),
        .out_ready (out_ready),
        .c1        (c1),
        .c2        (c2),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .xfer_cnt  (xfer_cnt)
    );

    // External select netlist: c2=1 -> w1; c2=0,c1=0 -> w2; c2=0,c1=1 -> w3.
    assign mux_y = c2 ? W1 : (c1 ? W3 : W2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete transaction with out_ready already high and the FSM in IDLE.
    task automatic do_xfer(input string tag, input logic exp_c1, input logic exp_c2,
                           input logic [2:0] exp_ack, input logic [2:0] exp_data,
                           input logic [7:0] exp_cnt);
        step();
        check({tag, "_c1_sel"}, {7'd0, c1}, {7'd0, exp_c1});
        check({tag, "_c2_sel"}, {7'd0, c2}, {7'd0, exp_c2});
        check({tag, "_ack_early"}, {5'd0, ack}, 8'd0);
        step();
        check({tag, "_ack"}, {5'd0, ack}, {5'd0, exp_ack});
        check({tag, "_data"}, {5'd0, out_data}, {5'd0, exp_data});
        check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, "_c1_hold"}, {7'd0, c1}, {7'd0, exp_c1});
        check({tag, "_c2_hold"}, {7'd0, c2}, {7'd0, exp_c2});
        step();
        check({tag, "_valid_clr"}, {7'd0, out_valid}, 8'd0);
        check({tag, "_ack_clr"}, {5'd0, ack}, 8'd0);
        check({tag, "_cnt"}, xfer_cnt, exp_cnt);
    endtask

    initial begin
        logic [1:0] idx;
        logic [2:0] ack_e;
        logic [2:0] data_e;

        rst_n     = 1'b0;
        req       = 3'b000;
        out_ready = 1'b0;
        step();
        step();
        check("rst_c1", {7'd0, c1}, 8'd0);
        check("rst_c2", {7'd0, c2}, 8'd0);
        check("rst_ack", {5'd0, ack}, 8'd0);
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_data", {5'd0, out_data}, 8'd0);
        check("rst_cnt", xfer_cnt, 8'd0);

        // All three request: grants w1, w2, w3 in order, 3 cycles apart.
        rst_n     = 1'b1;
        req       = 3'b111;
        out_ready = 1'b1;
        do_xfer("rr_w1", 1'b0, 1'b1, 3'b001, W1, 8'd1);
        do_xfer("rr_w2", 1'b0, 1'b0, 3'b010, W2, 8'd2);
        do_xfer("rr_w3", 1'b1, 1'b0, 3'b100, W3, 8'd3);
        req = 3'b000;
        step();
        check("idle_ack", {5'd0, ack}, 8'd0);
        check("idle_valid", {7'd0, out_valid}, 8'd0);
        check("idle_c1_kept", {7'd0, c1}, 8'd1);

        // w3 requests then drops before capture: abort, no ack, no capture.
        req = 3'b100;
        step();
        check("abort_c1", {7'd0, c1}, 8'd1);
        check("abort_c2", {7'd0, c2}, 8'd0);
        req = 3'b000;
        step();
        check("abort_ack", {5'd0, ack}, 8'd0);
        check("abort_valid", {7'd0, out_valid}, 8'd0);
        step();
        check("abort_ack2", {5'd0, ack}, 8'd0);
        check("abort_valid2", {7'd0, out_valid}, 8'd0);
        check("abort_cnt", xfer_cnt, 8'd3);
        // last_granted still w3, so w1 wins first.
        req = 3'b111;
        do_xfer("post_abort_w1", 1'b0, 1'b1, 3'b001, W1, 8'd4);
        req = 3'b000;
        step();

        // w2 alone with consumer stalled for 4 cycles.
        req       = 3'b010;
        out_ready = 1'b0;
        step();
        check("stall_c1", {7'd0, c1}, 8'd0);
        check("stall_c2", {7'd0, c2}, 8'd0);
        step();
        check("stall_ack", {5'd0, ack}, 8'd2);
        check("stall_data", {5'd0, out_data}, {5'd0, W2});
        check("stall_valid", {7'd0, out_valid}, 8'd1);
        req = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold_valid", {7'd0, out_valid}, 8'd1);
            check("stall_hold_data", {5'd0, out_data}, {5'd0, W2});
            check("stall_hold_ack", {5'd0, ack}, 8'd0);
            check("stall_hold_c2", {7'd0, c2}, 8'd0);
            check("stall_hold_cnt", xfer_cnt, 8'd4);
        end
        req       = 3'b000;
        out_ready = 1'b1;
        step();
        check("stall_release_valid", {7'd0, out_valid}, 8'd0);
        check("stall_release_cnt", xfer_cnt, 8'd5);
        out_ready = 1'b0;
        step();
        check("ready_ignored_cnt", xfer_cnt, 8'd5);

        // Reset while holding a word.
        req = 3'b111;
        step();
        check("hold_rst_sel_c1", {7'd0, c1}, 8'd1);
        step();
        check("hold_rst_ack", {5'd0, ack}, 8'd4);
        check("hold_rst_valid", {7'd0, out_valid}, 8'd1);
        rst_n = 1'b0;
        req   = 3'b000;
        step();
        check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        check("mid_rst_c1", {7'd0, c1}, 8'd0);
        check("mid_rst_c2", {7'd0, c2}, 8'd0);
        check("mid_rst_cnt", xfer_cnt, 8'd0);
        check("mid_rst_ack", {5'd0, ack}, 8'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_ack", {5'd0, ack}, 8'd0);
            check("post_rst_valid", {7'd0, out_valid}, 8'd0);
        end

        // 256 back-to-back transfers: strict 0,1,2 rotation and counter wrap.
        req = 3'b111;
        for (int i = 0; i < 256; i++) begin
            idx    = 2'(i % 3);
            ack_e  = 3'b001 << idx;
            data_e = (idx == 2'd0) ? W1 : ((idx == 2'd1) ? W2 : W3);
            do_xfer("b2b", idx == 2'd2, idx == 2'd0, ack_e, data_e, 8'((i + 1) % 256));
        end
        check("wrap_cnt", xfer_cnt, 8'd0);
        req = 3'b000;
        step();
        check("final_valid", {7'd0, out_valid}, 8'd0);
        check("final_ack", {5'd0, ack}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The port list SHALL be exactly the ports in REQ-003 to REQ-011.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  3  request lines; req[0]=w1 source, req[1]=w2 source, req[2]=w3 source.
REQ-006 mux_y  input  3  output of the external 3-bit 3:1 select netlist (c2=1 -> w1; c2=0,c1=0 -> w2; c2=0,c1=1 -> w3).
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 c1, c2  output  1 each  registered select lines driving the external mux.
REQ-009 ack  output  3  one-hot, one-cycle pulse: requester's word captured.
REQ-010 out_data, out_valid  output  3, 1  captured word and its valid flag.
REQ-011 xfer_cnt  output  8  count of completed consumer transfers.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SAMPLE, HOLD.
REQ-013 IDLE: if req!=0 at a rising edge, the block SHALL register the round-robin winner, drive its c1/c2 encoding and enter SAMPLE; else stay in IDLE with c1/c2 unchanged.
REQ-014 Round-robin: the search SHALL start at index (last_granted+1) mod 3 and ascend with wrap; last_granted updates only when ack fires.
REQ-015 Winner encoding SHALL be: index 0 -> c2=1,c1=0; index 1 -> c2=0,c1=0; index 2 -> c2=0,c1=1.
REQ-016 SAMPLE (exactly one cycle): if req[winner]=1 at the edge, the block SHALL load out_data<=mux_y, set out_valid=1, pulse ack[winner]=1 for one cycle and enter HOLD.
REQ-017 SAMPLE with req[winner]=0 at the edge: the block SHALL abort to IDLE with no ack, no capture and last_granted unchanged.
REQ-018 c1/c2 SHALL remain stable throughout SAMPLE and HOLD.
REQ-019 HOLD: out_valid and out_data SHALL stay stable until out_valid&out_ready at an edge; on that edge out_valid<=0, xfer_cnt<=xfer_cnt+1 (mod 256, wraps 255->0) and the FSM enters IDLE.
REQ-020 Latency: req seen at edge t -> c1/c2 valid after t; out_valid and ack high after edge t+1; minimum request-to-request period 3 cycles with out_ready held high.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 Requests changing in SAMPLE/HOLD SHALL not affect the current transaction; they are arbitrated at the next IDLE.
REQ-023 ack SHALL be at most one-hot and SHALL never be asserted outside the SAMPLE->HOLD edge.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL set: state=IDLE, c1=0, c2=0, ack=0, out_data=0, out_valid=0, xfer_cnt=0, last_granted=2 (first priority order w1,w2,w3).
REQ-025 Reset SHALL take priority over every other event, including mid-SAMPLE or mid-HOLD; the pending word is discarded with no ack.
REQ-026 The first rising edge with rst_n=1 SHALL perform normal IDLE evaluation.

Verification
REQ-027 After reset, req=3'b111, mux_y follows the select (w1=5, w2=3, w3=6), out_ready=1 -> acks in order 001,010,100; out_data 5,3,6; each 3 cycles apart; xfer_cnt=3.
REQ-028 req=3'b010 only, out_ready=0 for 4 cycles then 1 -> c2=0,c1=0; out_data=3 held with out_valid=1 for 5 cycles; ack a single pulse; xfer_cnt increments once.
REQ-029 req[2] asserted in IDLE, deasserted before the SAMPLE edge -> no ack, out_valid stays 0, FSM back in IDLE; a later req=3'b111 grants index 0 first.
REQ-030 rst_n=0 during HOLD with out_valid=1 -> next cycle out_valid=0, c1=c2=0, xfer_cnt=0, and no ack after release until a new request.
REQ-031 256 back-to-back transfers with out_ready=1 -> xfer_cnt wraps to 0; grants rotate strictly 0,1,2 under constant req=3'b111.
